// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
//   state_e   : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   F3_*      : RV32I load/store func3 encodings
//   byte_en_t : 4-lane byte enable
//   is_misaligned() : alignment rule used when DMEM_MISALIGN_CHECK_EN is defined
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [3:0] byte_en_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; byte is always aligned.
  function automatic logic is_misaligned(logic [2:0] func3, logic [1:0] addr_lo);
    return ((func3[1:0] == 2'b01) && addr_lo[0]) ||
           ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Bus between the CPU datapath (master) and the data memory responder (slave).
//   busReq/busWe/busFunc3/busAddr/busWData : request fields, driven by master
//   busRData/busReady                      : response, driven by slave
//   busErr                                 : misalignment flag, only with DMEM_MISALIGN_CHECK_EN
interface data_mem_responder_if;
  logic        busReq;
  logic        busWe;
  logic [2:0]  busFunc3;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        busReady;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        busErr;

  modport master (
    output busReq, busWe, busFunc3, busAddr, busWData,
    input  busRData, busReady, busErr
  );
  modport slave (
    input  busReq, busWe, busFunc3, busAddr, busWData,
    output busRData, busReady, busErr
  );
`else
  modport master (
    output busReq, busWe, busFunc3, busAddr, busWData,
    input  busRData, busReady
  );
  modport slave (
    input  busReq, busWe, busFunc3, busAddr, busWData,
    output busRData, busReady
  );
`endif
endinterface

// File: rtl/data_mem_responder_store_data_processor.sv
// Store-side lane steering: turns func3 + addr[1:0] + store data into byte enables and a
// lane-replicated write word. Counterpart of the CPU's load extractor.
//   func3_i   : store width (SB/SH/SW); anything else yields no enables
//   addr_lo_i : byte offset within the word (addr[0] ignored for SH)
//   wdata_i   : raw store data from the register file
//   be_o      : byte enables
//   data_o    : write word with the store data replicated across lanes
module store_data_processor
  import dmem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output byte_en_t    be_o,
  output logic [31:0] data_o
);

  always_comb begin
    be_o   = 4'b0000;
    data_o = wdata_i;
    case (func3_i)
      F3_SB: begin
        be_o   = 4'b0001 << addr_lo_i;
        data_o = {4{wdata_i[7:0]}};
      end
      F3_SH: begin
        be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o = {2{wdata_i[15:0]}};
      end
      F3_SW: begin
        be_o   = 4'b1111;
        data_o = wdata_i;
      end
      default: begin
        be_o   = 4'b0000;
        data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder for the RV32I multi-cycle CPU. Word RAM with byte-enable stores,
// raw 32-bit registered read data and a request/ready handshake with WAIT_STATES extra
// cycles of latency (busReq in cycle N -> busReady in cycle N+1+WAIT_STATES).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (RAM contents are not reset)
//   bus   : slave side of data_mem_responder_if
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses on busErr
// and suppress their RAM write / read-data update.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH + 2;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic [31:0]     mem_q [Depth];

  logic [AW-1:0]         acc_addr;
  logic                  acc_we;
  logic [2:0]            acc_f3;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  misaligned;
  logic                  enter_resp;
  byte_en_t              sdp_be, wr_be;
  logic [31:0]           sdp_data;

  // Upper address bits alias; they never reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.busAddr[31:AW];

  // With zero wait states the read happens on the accepting edge, before the capture
  // registers hold the request, so use the live bus fields while in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr = bus.busAddr[AW-1:0];
      acc_we   = bus.busWe;
      acc_f3   = bus.busFunc3;
    end else begin
      acc_addr = addr_q;
      acc_we   = we_q;
      acc_f3   = f3_q;
    end
  end

  assign acc_idx = acc_addr[AW-1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(acc_f3, acc_addr[1:0]);
  logic err_q, err_d;
`else
  assign misaligned = 1'b0;
`endif

  store_data_processor u_store_data_processor (
    .func3_i   (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .be_o      (sdp_be),
    .data_o    (sdp_data)
  );

  assign wr_be = (we_q && !misaligned) ? sdp_be : 4'b0000;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    f3_d       = f3_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    enter_resp = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.busReq) begin
          addr_d  = bus.busAddr[AW-1:0];
          we_d    = bus.busWe;
          f3_d    = bus.busFunc3;
          wdata_d = bus.busWData;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      ready_d = 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
      err_d   = misaligned;
`endif
      if (!acc_we && !misaligned) rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
`ifdef DMEM_MISALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Stores commit on the edge leaving RESP; a reset mid-access returns to IDLE first.
  always_ff @(posedge clk) begin
    if (state_q == RESP) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[addr_q[AW-1:2]][8*b +: 8] <= sdp_data[8*b +: 8];
      end
    end
  end

  assign bus.busRData = rdata_q;
  assign bus.busReady = ready_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bus.busErr   = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with zero wait states and one with three wait states.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;
  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus3 ();

  data_mem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(0)) u_dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0.slave)
  );

  data_mem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(3)) u_dut3 (
    .clk   (clk),
    .reset (rst3_n),
    .bus   (bus3.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus3.busReq = req; bus3.busWe = we; bus3.busFunc3 = f3;
      bus3.busAddr = addr; bus3.busWData = wdata;
    end else begin
      bus0.busReq = req; bus0.busWe = we; bus0.busFunc3 = f3;
      bus0.busAddr = addr; bus0.busWData = wdata;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus3.busReady : bus0.busReady;
  endfunction

  function automatic logic [31:0] rdat(input bit sel);
    return sel ? bus3.busRData : bus0.busRData;
  endfunction

  function automatic logic err_of(input bit sel);
`ifdef DMEM_MISALIGN_CHECK_EN
    return sel ? bus3.busErr : bus0.busErr;
`else
    return (sel && 1'b0);
`endif
  endfunction

  // One access: request in cycle 0, returns cycles-to-ready, read data, error flag and
  // busReady one cycle after the strobe.
  task automatic acc(input bit sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output int lat, output logic err,
                     output logic rdy_after);
    @(negedge clk);
    drive(sel, 1'b1, we, f3, addr, wdata);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) drive(sel, 1'b0, we, f3, addr, wdata);
    end while (!rdy(sel) && lat < 20);
    rdata = rdat(sel);
    err   = err_of(sel);
    @(negedge clk);
    rdy_after = rdy(sel);
  endtask

  logic [31:0] rd;
  int          lat;
  logic        err;
  logic        ra;
  logic [7:0]  pattern;
  logic        seen;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready0", 32'(bus0.busReady), 32'd0);
    chk("reset_rdata0", bus0.busRData, 32'd0);
    chk("reset_ready3", 32'(bus3.busReady), 32'd0);
    chk("reset_rdata3", bus3.busRData, 32'd0);
    chk("reset_err0", 32'(err_of(1'b0)), 32'd0);
    rst_n  = 1'b1;
    rst3_n = 1'b1;

    // Word store then load
    acc(1'b0, 1'b1, F3_SW, 32'h10, 32'hDEADBEEF, rd, lat, err, ra);
    chk("sw_latency", 32'(lat), 32'd1);
    chk("sw_ready_one_cycle", 32'(ra), 32'd0);
    acc(1'b0, 1'b0, F3_LW, 32'h10, 32'h0, rd, lat, err, ra);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_latency", 32'(lat), 32'd1);
    chk("lw_ready_one_cycle", 32'(ra), 32'd0);
    chk("lw_err", 32'(err), 32'd0);

    // Byte and halfword merges
    acc(1'b0, 1'b1, F3_SB, 32'h13, 32'h000000AA, rd, lat, err, ra);
    acc(1'b0, 1'b1, F3_SH, 32'h10, 32'h00001234, rd, lat, err, ra);
    acc(1'b0, 1'b0, F3_LW, 32'h10, 32'h0, rd, lat, err, ra);
    chk("sb_sh_merge", rd, 32'hAAAD1234);

    // Unsupported store width: still answered, no write, read data held
    acc(1'b0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, rd, lat, err, ra);
    chk("bad_f3_latency", 32'(lat), 32'd1);
    chk("store_keeps_rdata", rd, 32'hAAAD1234);
    acc(1'b0, 1'b0, F3_LW, 32'h10, 32'h0, rd, lat, err, ra);
    chk("bad_f3_no_write", rd, 32'hAAAD1234);

    // Address wrap at 64 words
    acc(1'b0, 1'b1, F3_SW, 32'h100, 32'h11111111, rd, lat, err, ra);
    acc(1'b0, 1'b0, F3_LW, 32'h000, 32'h0, rd, lat, err, ra);
    chk("addr_wrap", rd, 32'h11111111);

    // Misaligned word store
    acc(1'b0, 1'b1, F3_SW, 32'h20, 32'h12345678, rd, lat, err, ra);
    acc(1'b0, 1'b1, F3_SW, 32'h22, 32'h00000077, rd, lat, err, ra);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("misalign_err", 32'(err), 32'd1);
    chk("misalign_err_one_cycle", 32'(err_of(1'b0)), 32'd0);
`endif
    chk("misalign_latency", 32'(lat), 32'd1);
    acc(1'b0, 1'b0, F3_LW, 32'h20, 32'h0, rd, lat, err, ra);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("misalign_word", rd, 32'h12345678);
`else
    chk("misalign_word", rd, 32'h00000077);
`endif

    // Three wait states, request held through WAIT, data changed mid-access
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, F3_SW, 32'h40, 32'h00000001);
    pattern = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) bus3.busWData = 32'h00000002;
      pattern[c-1] = bus3.busReady;
      if (c == 4) bus3.busReq = 1'b0;
    end
    chk("wait3_ready_pattern", 32'(pattern), 32'h00000008);
    acc(1'b1, 1'b0, F3_LW, 32'h40, 32'h0, rd, lat, err, ra);
    chk("wait3_captured_wdata", rd, 32'h00000001);
    chk("wait3_latency", 32'(lat), 32'd4);
    chk("wait3_ready_one_cycle", 32'(ra), 32'd0);

    // Reset in the middle of WAIT aborts the store
    acc(1'b1, 1'b1, F3_SW, 32'h20, 32'hCAFEF00D, rd, lat, err, ra);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, F3_SW, 32'h20, 32'h00000055);
    @(negedge clk);
    bus3.busReq = 1'b0;
    rst3_n = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus3.busReady;
    end
    rst3_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus3.busReady;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    chk("abort_rdata_cleared", bus3.busRData, 32'd0);
    acc(1'b1, 1'b0, F3_LW, 32'h20, 32'h0, rd, lat, err, ra);
    chk("abort_no_write", rd, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
